// File: rtl/dmem_arb_pkg.sv
// Shared types and default constants for the data-memory arbiter.
// Optional feature macro: DMEM_RANGE_CHECK_EN (see dmem_arbiter.sv).
package dmem_arb_pkg;

  localparam int DEFAULT_DEPTH        = 256;
  localparam int DEFAULT_STARVE_LIMIT = 4;

  // Which requester owns the memory port in the current cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_e;

  // Arbitration priority state.
  typedef enum logic {
    CPU_PRI   = 1'b0,
    DMA_BOOST = 1'b1
  } arb_state_e;

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// DMA starvation tracking: counts consecutive cycles the DMA request is
// blocked and raises boost so the DMA wins exactly one grant.
module dmem_arb_starve_ctr
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic dma_req,
  input  logic dma_gnt,
  output logic boost
);

  arb_state_e state, state_next;
  logic [7:0] starve_cnt, cnt_next;
  logic [8:0] cnt_inc;
  logic       blocked;

  // Next counter value and priority state from this cycle's DMA outcome.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    cnt_next   = 8'd0;
    state_next = state;
    blocked    = dma_req && !dma_gnt;
    cnt_inc    = {1'b0, starve_cnt} + 9'd1;

    if (blocked) begin
      cnt_next = (cnt_inc >= 9'(STARVE_LIMIT)) ? 8'(STARVE_LIMIT) : cnt_inc[7:0];
    end

    case (state)
      CPU_PRI:   if (blocked && cnt_inc >= 9'(STARVE_LIMIT)) state_next = DMA_BOOST;
      DMA_BOOST: if (dma_gnt || !dma_req) state_next = CPU_PRI;
      default:   state_next = CPU_PRI;
    endcase
  end

  // Counter and state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= CPU_PRI;
      starve_cnt <= 8'd0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      state      <= state_next;
      starve_cnt <= cnt_next;
    end
  end

  assign boost = (state == DMA_BOOST);

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between the CPU MEM stage and a DMA port.
// CPU has fixed priority; a starved DMA gets one boosted grant.
// Optional feature macro: DMEM_RANGE_CHECK_EN -- accesses at addr >= DEPTH are
// granted but not forwarded, and answer next cycle with rvalid, rdata=0, err=1.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int DEPTH        = DEFAULT_DEPTH,
  parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_err,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata
);

`ifdef DMEM_RANGE_CHECK_EN
  localparam bit RANGE_CHECK = 1'b1;
`else
  localparam bit RANGE_CHECK = 1'b0;
`endif

  owner_e            winner;
  logic              boost;
  logic              win_we;
  logic              win_oor;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  dmem_arb_starve_ctr #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk     (clk),
    .rst_n   (rst_n),
    .dma_req (dma_req),
    .dma_gnt (dma_gnt),
    .boost   (boost)
  );

  // Pick the owner; nobody wins while reset is asserted.
  always_comb begin
    winner = OWN_NONE;
    if (rst_n) begin
      if (boost) winner = dma_req ? OWN_DMA : (cpu_req ? OWN_CPU : OWN_NONE);
      else       winner = cpu_req ? OWN_CPU : (dma_req ? OWN_DMA : OWN_NONE);
    end
  end

  // Route the winner onto the memory port; out-of-range accesses are suppressed.
  always_comb begin
    win_we    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    case (winner)
      OWN_CPU: begin win_we = cpu_we; win_addr = cpu_addr; win_wdata = cpu_wdata; end
      OWN_DMA: begin win_we = dma_we; win_addr = dma_addr; win_wdata = dma_wdata; end
      default: ;
    endcase
    win_oor   = RANGE_CHECK && (winner != OWN_NONE) && (win_addr >= ADDR_W'(DEPTH));
    mem_addr  = win_addr;
    mem_wdata = win_wdata;
    mem_write = (winner != OWN_NONE) &&  win_we && !win_oor;
    mem_read  = (winner != OWN_NONE) && !win_we && !win_oor;
  end

  assign cpu_gnt = (winner == OWN_CPU);
  assign dma_gnt = (winner == OWN_DMA);

  // Registered responses: one-cycle rvalid for reads and range errors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      cpu_err    <= 1'b0;
      dma_rvalid <= 1'b0;
      dma_rdata  <= '0;
      dma_err    <= 1'b0;
    end else begin
      cpu_rvalid <= 1'b0;
      cpu_err    <= 1'b0;
      dma_rvalid <= 1'b0;
      dma_err    <= 1'b0;
      if (cpu_gnt && (win_oor || !win_we)) begin
        cpu_rvalid <= 1'b1;
        cpu_err    <= win_oor;
        cpu_rdata  <= win_oor ? '0 : mem_rdata;
      end
      if (dma_gnt && (win_oor || !win_we)) begin
        dma_rvalid <= 1'b1;
        dma_err    <= win_oor;
        dma_rdata  <= win_oor ? '0 : mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by random
// traffic, all checked against a behavioural model of the arbitration rules.
// Honours DMEM_RANGE_CHECK_EN the same way the design does.
module tb_dmem_arbiter;

  localparam int ADDR_W       = 32;
  localparam int DATA_W       = 32;
  localparam int DEPTH        = 256;
  localparam int STARVE_LIMIT = 4;

`ifdef DMEM_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cpu_req, cpu_we, dma_req, dma_we;
  logic [ADDR_W-1:0] cpu_addr, dma_addr, mem_addr;
  logic [DATA_W-1:0] cpu_wdata, dma_wdata, mem_wdata, mem_rdata;
  logic              cpu_gnt, cpu_rvalid, cpu_err, dma_gnt, dma_rvalid, dma_err;
  logic [DATA_W-1:0] cpu_rdata, dma_rdata;
  logic              mem_write, mem_read;

  // Bench-side memory and its reference copy
  logic              mem_init;
  logic [31:0]       tb_mem  [512];
  logic [31:0]       ref_mem [512];

  // Reference model state
  int                blocked;
  logic [31:0]       exp_cpu_rd, exp_dma_rd;
  logic              last_cg, last_dg;
  logic [15:0]       pattern;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .ADDR_W (ADDR_W), .DATA_W (DATA_W), .DEPTH (DEPTH), .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk (clk), .rst_n (rst_n),
    .cpu_req (cpu_req), .cpu_we (cpu_we), .cpu_addr (cpu_addr), .cpu_wdata (cpu_wdata),
    .cpu_gnt (cpu_gnt), .cpu_rvalid (cpu_rvalid), .cpu_rdata (cpu_rdata), .cpu_err (cpu_err),
    .dma_req (dma_req), .dma_we (dma_we), .dma_addr (dma_addr), .dma_wdata (dma_wdata),
    .dma_gnt (dma_gnt), .dma_rvalid (dma_rvalid), .dma_rdata (dma_rdata), .dma_err (dma_err),
    .mem_addr (mem_addr), .mem_wdata (mem_wdata), .mem_write (mem_write),
    .mem_read (mem_read), .mem_rdata (mem_rdata)
  );

  function automatic logic [31:0] pat(int i);
    return 32'(i) * 32'h9E3779B1;
  endfunction

  // Single-port memory: combinational read, write on the rising edge
  assign mem_rdata = tb_mem[mem_addr[8:0]];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 512; i++) tb_mem[i] <= pat(i);
    end else if (mem_write) begin
      tb_mem[mem_addr[8:0]] <= mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    blocked    = 0;
    exp_cpu_rd = '0;
    exp_dma_rd = '0;
  endtask

  task automatic set_cpu(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
    cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic set_dma(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
    dma_req = req; dma_we = we; dma_addr = a; dma_wdata = d;
  endtask

  // One clock: check the grant and memory port mid-cycle, then the responses after the edge.
  task automatic cycle();
    logic        eg_c, eg_d, any, we, oor, nv_c, nv_d, ne_c, ne_d;
    logic [31:0] a, wd;
    @(negedge clk);
    // DMA wins if the CPU is idle or the DMA has been blocked STARVE_LIMIT cycles in a row
    eg_d = dma_req && (!cpu_req || blocked >= STARVE_LIMIT);
    eg_c = cpu_req && !eg_d;
    any  = eg_c || eg_d;
    a    = eg_c ? cpu_addr  : (eg_d ? dma_addr  : 32'd0);
    wd   = eg_c ? cpu_wdata : (eg_d ? dma_wdata : 32'd0);
    we   = eg_c ? cpu_we    : (eg_d ? dma_we    : 1'b0);
    oor  = any && RC && (a >= 32'(DEPTH));
    check("cpu_gnt",   cpu_gnt,   eg_c);
    check("dma_gnt",   dma_gnt,   eg_d);
    check("mem_addr",  mem_addr,  a);
    check("mem_wdata", mem_wdata, wd);
    check("mem_read",  mem_read,  any && !we && !oor);
    check("mem_write", mem_write, any &&  we && !oor);
    last_cg = cpu_gnt;
    last_dg = dma_gnt;
    nv_c = eg_c && (!we || oor);
    nv_d = eg_d && (!we || oor);
    ne_c = eg_c && oor;
    ne_d = eg_d && oor;
    if (nv_c) exp_cpu_rd = oor ? 32'd0 : ref_mem[a[8:0]];
    if (nv_d) exp_dma_rd = oor ? 32'd0 : ref_mem[a[8:0]];
    if (any && we && !oor) ref_mem[a[8:0]] = wd;
    blocked = (dma_req && !eg_d) ? blocked + 1 : 0;
    @(posedge clk);
    #1;
    check("cpu_rvalid", cpu_rvalid, nv_c);
    check("cpu_rdata",  cpu_rdata,  exp_cpu_rd);
    check("cpu_err",    cpu_err,    ne_c);
    check("dma_rvalid", dma_rvalid, nv_d);
    check("dma_rdata",  dma_rdata,  exp_dma_rd);
    check("dma_err",    dma_err,    ne_d);
  endtask

  // Run n cycles with the current requests held, recording which cycles the DMA won.
  task automatic run_record(input int n);
    pattern = '0;
    for (int i = 0; i < n; i++) begin
      cycle();
      pattern[i] = last_dg;
    end
  endtask

  task automatic reset_outputs_zero(input string tag);
    check({tag, "_cpu_gnt"},    cpu_gnt,    1'b0);
    check({tag, "_dma_gnt"},    dma_gnt,    1'b0);
    check({tag, "_mem_write"},  mem_write,  1'b0);
    check({tag, "_mem_read"},   mem_read,   1'b0);
    check({tag, "_mem_addr"},   mem_addr,   32'd0);
    check({tag, "_cpu_rvalid"}, cpu_rvalid, 1'b0);
    check({tag, "_cpu_rdata"},  cpu_rdata,  32'd0);
    check({tag, "_dma_rvalid"}, dma_rvalid, 1'b0);
    check({tag, "_dma_rdata"},  dma_rdata,  32'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    mem_init = 1'b1;
    for (int i = 0; i < 512; i++) ref_mem[i] = pat(i);
    model_reset();
    // Requests during reset must not leak onto the memory port
    set_cpu(1'b1, 1'b1, 32'd5, 32'h1111_1111);
    set_dma(1'b1, 1'b0, 32'd6, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_outputs_zero("reset");
    mem_init = 1'b0;
    set_cpu(1'b0, 1'b0, 32'd0, 32'd0);
    set_dma(1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // CPU write then read-back of the same word
    set_cpu(1'b1, 1'b1, 32'd5, 32'hDEAD_BEEF);
    cycle();
    set_cpu(1'b1, 1'b0, 32'd5, 32'd0);
    cycle();
    check("t1_rdata", cpu_rdata, 32'hDEAD_BEEF);
    set_cpu(1'b0, 1'b0, 32'd0, 32'd0);
    cycle();

    // Both requesting continuously: four CPU grants then one DMA grant, repeating
    set_cpu(1'b1, 1'b0, 32'd7, 32'd0);
    set_dma(1'b1, 1'b0, 32'd8, 32'd0);
    run_record(10);
    check("t2_dma_pattern", pattern[9:0], 10'b10_0001_0000);
    set_cpu(1'b0, 1'b0, 32'd0, 32'd0);
    set_dma(1'b0, 1'b0, 32'd0, 32'd0);
    cycle();

    // DMA write, CPU reads it back the next cycle
    set_dma(1'b1, 1'b1, 32'd10, 32'h1234_5678);
    cycle();
    set_dma(1'b0, 1'b0, 32'd0, 32'd0);
    set_cpu(1'b1, 1'b0, 32'd10, 32'd0);
    cycle();
    check("t3_rdata", cpu_rdata, 32'h1234_5678);
    set_cpu(1'b0, 1'b0, 32'd0, 32'd0);
    cycle();

    // Reset mid-stream with three blocked DMA cycles and a read response pending
    set_cpu(1'b1, 1'b0, 32'd3, 32'd0);
    set_dma(1'b1, 1'b1, 32'd4, 32'hAAAA_5555);
    repeat (3) cycle();
    check("t4_pre_rvalid", cpu_rvalid, 1'b1);
    rst_n = 1'b0;
    #1;
    reset_outputs_zero("t4_reset");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_record(5);
    check("t4_fresh_boost", pattern[4:0], 5'b10000);
    set_cpu(1'b0, 1'b0, 32'd0, 32'd0);
    set_dma(1'b0, 1'b0, 32'd0, 32'd0);
    cycle();

    // Out-of-range CPU read
    set_cpu(1'b1, 1'b0, 32'd300, 32'd0);
    cycle();
    check("t5_err", cpu_err, RC);
    set_cpu(1'b0, 1'b0, 32'd0, 32'd0);
    cycle();

    // DMA gives up after two blocked cycles: the count starts over
    set_cpu(1'b1, 1'b0, 32'd20, 32'd0);
    set_dma(1'b1, 1'b0, 32'd21, 32'd0);
    run_record(2);
    check("t6_no_dma", pattern[1:0], 2'b00);
    set_dma(1'b0, 1'b0, 32'd0, 32'd0);
    cycle();
    set_dma(1'b1, 1'b0, 32'd21, 32'd0);
    run_record(5);
    check("t6_restart", pattern[4:0], 5'b10000);
    set_cpu(1'b0, 1'b0, 32'd0, 32'd0);
    set_dma(1'b0, 1'b0, 32'd0, 32'd0);
    cycle();

    // Random traffic: requests stay stable until granted, occasionally withdrawn
    for (int k = 0; k < 400; k++) begin
      if (!cpu_req || last_cg)
        set_cpu($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 7) == 0) ? $urandom_range(0, 511) : $urandom_range(0, 15),
                $urandom);
      else if ($urandom_range(0, 15) == 0)
        cpu_req = 1'b0;
      if (!dma_req || last_dg)
        set_dma($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 7) == 0) ? $urandom_range(0, 511) : $urandom_range(0, 15),
                $urandom);
      else if ($urandom_range(0, 15) == 0)
        dma_req = 1'b0;
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: the CPU MEM-stage load/store port and a DMA/loader port.
- Gives the CPU fixed priority, with a starvation counter that forces one DMA grant after STARVE_LIMIT blocked cycles.
- Drives the memory's address, write-data, write-enable and read-enable lines, and returns registered read data to the requester that won.

Parameters:
- ADDR_W, 32, address width of both ports and the memory.
- DATA_W, 32, data width.
- DEPTH, 256, number of memory words; used only by the range check.
- STARVE_LIMIT, 4, consecutive blocked DMA cycles before DMA is boosted (1..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  CPU access request.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  word address.
- cpu_wdata  in  DATA_W  write data.
- cpu_gnt  out  1  access accepted this cycle.
- cpu_rvalid  out  1  read data valid, one cycle after a read grant.
- cpu_rdata  out  DATA_W  registered read data.
- cpu_err  out  1  range error pulse, aligned with rvalid.
- dma_req, dma_we, dma_addr, dma_wdata, dma_gnt, dma_rvalid, dma_rdata, dma_err: same meanings as the CPU port.
- mem_addr  out  ADDR_W  to memory.
- mem_wdata  out  DATA_W  to memory.
- mem_write  out  1  to memory; write commits on the rising clk edge.
- mem_read  out  1  to memory.
- mem_rdata  in  DATA_W  combinational read data from memory.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = CPU_PRI, starve_cnt = 0.
  - All rvalid, rdata and err registers are 0.
  - gnt and mem_* outputs are forced to 0 while rst_n is low.
- Arbitration is combinational and made each cycle. At most one gnt is high.
  - CPU_PRI: CPU wins if cpu_req is high, otherwise DMA wins if dma_req is high.
  - DMA_BOOST: DMA wins if dma_req is high, otherwise CPU wins.
- gnt=1 means the access is consumed at this rising edge.
- Requesters hold req, we, addr and wdata stable until they see gnt.
- Dropping req without a grant is legal; nothing is recorded.
- The winner's addr and wdata are muxed onto mem_addr and mem_wdata.
  - mem_write = winner_we.
  - mem_read = ~winner_we.
- With no winner: mem_read = mem_write = 0, and mem_addr and mem_wdata are 0.
- Read latency is 1 cycle:
  - On a read grant, mem_rdata is registered into the winner's rdata.
  - The winner's rvalid is high for exactly the following cycle.
- Writes produce no rvalid.
- rdata holds its last value when rvalid is 0.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) each cycle dma_req is high and dma_gnt is low.
  - Clears on any dma_gnt.
  - Clears when dma_req is low.
- State transitions:
  - CPU_PRI -> DMA_BOOST at the edge where starve_cnt would reach STARVE_LIMIT.
  - DMA_BOOST -> CPU_PRI after one DMA grant, or when dma_req falls.
- Back-to-back grants to either port are allowed every cycle. There is no dead cycle.
- Read-after-write to the same address on consecutive cycles returns the new data, because the write commits before the next combinational read.
- Both requests on the same cycle: only the winner is granted; the loser stays pending.

Optional Feature:
- DMEM_RANGE_CHECK_EN defined:
  - A granted access with addr >= DEPTH still gets gnt, but mem_read and mem_write stay 0.
  - The next cycle the requester gets rvalid=1 (for reads and writes), rdata=0 and err=1.
- Not defined:
  - Addresses pass through unchecked.
  - cpu_err and dma_err are tied 0.

Decomposition:
- Package dmem_arb_pkg holds:
  - the owner enum OWN_NONE/OWN_CPU/OWN_DMA;
  - the state enum CPU_PRI/DMA_BOOST;
  - the default constants for DEPTH and STARVE_LIMIT.
- Sub-module dmem_arb_starve_ctr contains the saturating counter and the boost flag.
- The arbiter top keeps the grant mux and the response registers.

Test Plan:
1. Reset, then cpu_req write addr 5 data 0xDEADBEEF, then a read of addr 5 -> cpu_gnt=1 both cycles, cpu_rvalid=1 one cycle after the read, cpu_rdata=0xDEADBEEF, dma_gnt=0.
2. cpu_req and dma_req held high continuously, STARVE_LIMIT=4 -> CPU granted 4 cycles, DMA granted on cycle 5, CPU granted again on cycle 6; the pattern repeats.
3. DMA write addr 10 = 0x12345678, then a CPU read of addr 10 in the next cycle -> cpu_rdata=0x12345678, dma_rvalid stays 0.
4. rst_n pulled low mid-stream with starve_cnt=3 and rvalid pending -> all outputs 0 immediately; after release, DMA needs 4 fresh blocked cycles for a boost.
5. With DMEM_RANGE_CHECK_EN: CPU read addr 300 -> cpu_gnt=1, mem_read=0, next cycle cpu_rvalid=1, cpu_rdata=0, cpu_err=1. Without the macro: mem_read=1 and cpu_err=0.
6. dma_req dropped before grant after 2 blocked cycles -> counter clears, no DMA access, state remains CPU_PRI.
